// File: rtl/frank_pkg.sv
// Shared definitions for the FRANK6000 instruction loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the loader state encoding, the instruction word width and the default
// end-of-program marker value.
package frank_pkg;

    localparam int INSTR_W = 16;

    // Default instruction value that terminates a load; never written to memory.
    localparam logic [INSTR_W-1:0] END_MARKER_DEF = 16'hFFFF;

    // Loader state encoding. CHK is only reachable when the checksum build
    // option is enabled.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_CHK  = 2'b11;

    // True when a word is the end-of-program marker.
    function automatic logic is_end_marker(
        input logic [INSTR_W-1:0] word,
        input logic [INSTR_W-1:0] marker
    );
        return word == marker;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Single-clock show-ahead FIFO buffering received instruction words.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push while full is discarded unless a pop happens the same cycle.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset (empties the FIFO)
//   push, din        write request and data
//   pop              read request; the head advances at the clock edge
//   dout             current head word (valid while empty is low)
//   full, empty      occupancy status
module instr_fifo #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int DATA_W          = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [FIFO_DEPTH_LOG2:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2:0] rd_ptr;

    logic do_pop;
    logic do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                   (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);

    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads UART-received instruction words into FRANK6000 program memory from address 0.
// Latency: o_mem_we asserts 2 cycles after i_rx_dv when the FIFO is empty and memory is ready.
// Backpressure: i_mem_ready low stalls pops; words arriving to a full FIFO are dropped (o_fifo_ovf).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_load_start                 pulse; starts a load from IDLE or DONE
//   i_rx_instr, i_rx_dv          received word and its one-cycle valid pulse
//   i_mem_ready                  memory accepts a write this cycle
//   o_mem_we/addr/wdata          program memory write port (addr/wdata hold when we is low)
//   o_cpu_halt                   high while loading
//   o_load_done                  high in DONE
//   o_instr_count                words written in the current/last load
//   o_fifo_ovf, o_mem_full       sticky status flags, cleared on a new load
//   o_chk_err                    checksum mismatch (only with INSTR_LOADER_CHKSUM_EN)
//
// Build option INSTR_LOADER_CHKSUM_EN: after the end marker one more word is
// read and compared against the 16-bit sum of all written words.
module instr_loader
    import frank_pkg::*;
#(
    parameter int                 ADDR_W          = 8,
    parameter int                 FIFO_DEPTH_LOG2 = 2,
    parameter logic [INSTR_W-1:0] END_MARKER      = END_MARKER_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_start,
    input  logic [INSTR_W-1:0] i_rx_instr,
    input  logic               i_rx_dv,
    input  logic               i_mem_ready,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [INSTR_W-1:0] o_mem_wdata,
    output logic               o_cpu_halt,
    output logic               o_load_done,
    output logic [ADDR_W:0]    o_instr_count,
    output logic               o_fifo_ovf,
    output logic               o_mem_full
`ifdef INSTR_LOADER_CHKSUM_EN
    ,
    output logic               o_chk_err
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W:0]    count;

    logic               f_push;
    logic               f_pop;
    logic               f_clr;
    logic [INSTR_W-1:0] f_head;
    logic               f_full;
    logic               f_empty;

    logic               accept;
    logic               start;
    logic               pop_ok;
    logic               head_is_marker;
    logic               marker_pop;
    logic               wr_pop;
    logic               last_wr;
    logic               ovf_evt;

`ifdef INSTR_LOADER_CHKSUM_EN
    logic [INSTR_W-1:0] sum;
    logic               chk_pop;

    // The checksum word may still be arriving after the marker has been popped,
    // so the FIFO keeps accepting words while in CHK.
    assign accept  = (state == ST_LOAD) || (state == ST_CHK);
    assign chk_pop = pop_ok && (state == ST_CHK);
`else
    assign accept  = (state == ST_LOAD);
`endif

    assign start          = i_load_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign pop_ok         = accept && !f_empty && i_mem_ready;
    assign head_is_marker = is_end_marker(f_head, END_MARKER);
    assign marker_pop     = pop_ok && (state == ST_LOAD) && head_is_marker;
    assign wr_pop         = pop_ok && (state == ST_LOAD) && !head_is_marker;
    assign last_wr        = wr_pop && (wr_addr == LAST_ADDR);

    assign f_push  = accept && i_rx_dv;
    assign f_pop   = pop_ok;
    // Same-cycle pop frees a slot, so only a push into a full, non-popping FIFO overflows.
    assign ovf_evt = f_push && f_full && !f_pop;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_wr) begin
                    state_nxt = ST_DONE;
                end else if (marker_pop) begin
`ifdef INSTR_LOADER_CHKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            default: begin
`ifdef INSTR_LOADER_CHKSUM_EN
                if (chk_pop) begin
                    state_nxt = ST_DONE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
        endcase
    end

    // Leftover words are discarded by clearing the FIFO on the edge that enters DONE.
    assign f_clr = i_rst || ((state_nxt == ST_DONE) && (state != ST_DONE));

    instr_fifo #(
        .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .DATA_W          (INSTR_W)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (f_clr),
        .push  (f_push),
        .pop   (f_pop),
        .din   (i_rx_instr),
        .dout  (f_head),
        .full  (f_full),
        .empty (f_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            wr_addr     <= '0;
            count       <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_fifo_ovf  <= 1'b0;
            o_mem_full  <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_mem_we <= wr_pop;
            if (start) begin
                wr_addr    <= '0;
                count      <= '0;
                o_fifo_ovf <= 1'b0;
                o_mem_full <= 1'b0;
            end else begin
                if (wr_pop) begin
                    o_mem_addr  <= wr_addr;
                    o_mem_wdata <= f_head;
                    count       <= count + CNT_ONE;
                    // The address saturates at the top of memory instead of wrapping.
                    if (last_wr) begin
                        o_mem_full <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + ADDR_ONE;
                    end
                end
                if (ovf_evt) begin
                    o_fifo_ovf <= 1'b1;
                end
            end
        end
    end

`ifdef INSTR_LOADER_CHKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum       <= '0;
            o_chk_err <= 1'b0;
        end else if (start) begin
            sum       <= '0;
            o_chk_err <= 1'b0;
        end else begin
            if (wr_pop) begin
                sum <= sum + f_head;
            end
            if (chk_pop && (f_head != sum)) begin
                o_chk_err <= 1'b1;
            end
        end
    end
`endif

    assign o_cpu_halt    = (state == ST_LOAD);
    assign o_load_done   = (state == ST_DONE);
    assign o_instr_count = count;

endmodule
